// File: rtl/capture_sequencer_pkg.sv
// rtl/capture_sequencer_pkg.sv - shared state codes and widths for the capture sequencer
package capture_sequencer_pkg;

  localparam int SAMPLE_W   = 14;
  localparam int AW_DEFAULT = 10;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PREFILL   = 3'd1,
    ST_WAIT_TRIG = 3'd2,
    ST_POST      = 3'd3,
    ST_READOUT   = 3'd4,
    ST_HOLDOFF   = 3'd5
  } state_t;

endpackage

// File: rtl/capture_sequencer_if.sv
// rtl/capture_sequencer_if.sv - readout stream from the sequencer to the UART framer
interface capture_sequencer_if;
  import capture_sequencer_pkg::*;

  logic [SAMPLE_W-1:0] rd_data;
  logic                rd_valid;
  logic                rd_ready;
  logic                rd_last;

  modport master (output rd_data, output rd_valid, output rd_last, input rd_ready);
  modport slave  (input rd_data, input rd_valid, input rd_last, output rd_ready);

endinterface

// File: rtl/capture_sequencer_ram.sv
// rtl/capture_sequencer_ram.sv - simple dual-port sample buffer, sync write, registered read
module capture_sequencer_ram #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10,
  parameter int W     = 14
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  // write port: one sample per enabled cycle
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // read port: rdata only changes when a read is issued, so a fetched word waits here
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/capture_sequencer.sv
// rtl/capture_sequencer.sv - arm/trigger/capture/readout controller around a circular sample buffer
module capture_sequencer
  import capture_sequencer_pkg::*;
#(
  parameter int DEPTH        = 1024,
  parameter int AW           = AW_DEFAULT,
  parameter int PRETRIG      = 256,
  parameter int AUTO_TIMEOUT = 1000000,
  parameter int HOLDOFF      = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [SAMPLE_W-1:0] adc_in,
  input  logic                trig_in,
  input  logic                arm,
  input  logic                abort,
  input  logic                single,
  input  logic                auto_mode,
  input  logic                force_trig,
  capture_sequencer_if.master rd,
  output logic                busy,
  output logic [2:0]          state_o,
  output logic [15:0]         missed_trig
);

  localparam logic [31:0]   PRE_END     = 32'(PRETRIG - 1);
  localparam logic [31:0]   POST_END    = 32'(DEPTH - PRETRIG - 1);
  localparam logic [31:0]   TIMEOUT_END = 32'(AUTO_TIMEOUT - 1);
  localparam logic [31:0]   HOLD_END    = 32'(HOLDOFF - 1);
  localparam logic [AW:0]   NWORDS      = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LAST_IDX    = (AW+1)'(DEPTH - 1);
  localparam logic [AW-1:0] PRE_OFS     = AW'(PRETRIG);

  state_t              state, state_nx;
  logic [31:0]         cnt, cnt_nx;
  logic [AW-1:0]       wr_ptr, trig_addr, rd_ptr;
  logic [AW:0]         rd_cnt;
  logic                pend, pend_last;
  logic [SAMPLE_W-1:0] ram_q;
  logic                wr_en, rd_en, trig_hit, load, accept, enter_readout;
  logic [SAMPLE_W-1:0] rd_data_q;
  logic                rd_valid_q, rd_last_q;

  assign accept        = rd_valid_q & rd.rd_ready;
  // a fetched word moves to the output register once that register is empty or draining
  assign load          = pend & (~rd_valid_q | rd.rd_ready);
  assign rd_en         = (state == ST_READOUT) & ~abort & (rd_cnt != NWORDS) & (~pend | load);
  assign enter_readout = (state_nx == ST_READOUT) & (state != ST_READOUT);

  // next state, write enable and the shared phase counter (prefill/timeout/post/holdoff)
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt + 32'd1;
    wr_en    = 1'b0;
    trig_hit = 1'b0;
    case (state)
      ST_IDLE: begin
        if (arm) state_nx = ST_PREFILL;
      end
      ST_PREFILL: begin
        wr_en = 1'b1;
        if (cnt == PRE_END) state_nx = ST_WAIT_TRIG;
      end
      ST_WAIT_TRIG: begin
        wr_en    = 1'b1;
        trig_hit = trig_in | force_trig | (auto_mode & (cnt == TIMEOUT_END));
        if (trig_hit) state_nx = (POST_END == 32'd0) ? ST_READOUT : ST_POST;
      end
      ST_POST: begin
        wr_en = 1'b1;
        if (cnt == POST_END) state_nx = ST_READOUT;
      end
      ST_READOUT: begin
        if (accept & rd_last_q) state_nx = single ? ST_IDLE : ST_HOLDOFF;
      end
      ST_HOLDOFF: begin
        if (cnt == HOLD_END) state_nx = ST_PREFILL;
      end
      default: state_nx = ST_IDLE;
    endcase
    if (abort) begin
      state_nx = ST_IDLE;
      wr_en    = 1'b0;
    end
    // the trigger sample is already post sample 1, so POST starts counting at 1
    if (state_nx != state) cnt_nx = (state_nx == ST_POST) ? 32'd1 : 32'd0;
  end

  // state register and phase counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= 32'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // write pointer runs continuously across re-arms; remember where the trigger sample landed
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      trig_addr <= '0;
    end else if (wr_en) begin
      wr_ptr <= wr_ptr + 1'b1;
      if (trig_hit) trig_addr <= wr_ptr;
    end
  end

  // fetch side: rd_ptr is the next address to fetch, pend marks a word waiting in ram_q
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr    <= '0;
      rd_cnt    <= '0;
      pend      <= 1'b0;
      pend_last <= 1'b0;
    end else if (enter_readout) begin
      rd_ptr    <= ((state == ST_WAIT_TRIG) ? wr_ptr : trig_addr) - PRE_OFS;
      rd_cnt    <= '0;
      pend      <= 1'b0;
      pend_last <= 1'b0;
    end else if (abort) begin
      pend <= 1'b0;
    end else begin
      if (rd_en) begin
        rd_ptr    <= rd_ptr + 1'b1;
        rd_cnt    <= rd_cnt + 1'b1;
        pend_last <= (rd_cnt == LAST_IDX);
      end
      pend <= rd_en | (pend & ~load);
    end
  end

  // output register: holds data/last steady while the consumer stalls
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
    end else if (abort) begin
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
    end else if (load) begin
      rd_data_q  <= ram_q;
      rd_valid_q <= 1'b1;
      rd_last_q  <= pend_last;
    end else if (accept) begin
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
    end
  end

  // count triggers that arrive while the sequencer cannot act on them
  always_ff @(posedge clk) begin
    if (reset) begin
      missed_trig <= 16'd0;
    end else if (trig_in && (missed_trig != 16'hFFFF) &&
                 (state == ST_PREFILL || state == ST_READOUT || state == ST_HOLDOFF)) begin
      missed_trig <= missed_trig + 16'd1;
    end
  end

  capture_sequencer_ram #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .W     (SAMPLE_W)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (adc_in),
    .re    (rd_en),
    .raddr (rd_ptr),
    .rdata (ram_q)
  );

  assign rd.rd_data  = rd_data_q;
  assign rd.rd_valid = rd_valid_q;
  assign rd.rd_last  = rd_last_q;
  assign busy        = (state != ST_IDLE);
  assign state_o     = state;

endmodule

// File: tb/tb_capture_sequencer.sv
// tb/tb_capture_sequencer.sv - self-checking bench for capture_sequencer
module tb_capture_sequencer;
  import capture_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [13:0] adc_in = 14'd0;
  logic        trig_in = 1'b0, arm = 1'b0, abort = 1'b0, single = 1'b1;
  logic        auto_mode = 1'b0, force_trig = 1'b0;
  logic        busy;
  logic [2:0]  state_o;
  logic [15:0] missed_trig;

  capture_sequencer_if rd_if();

  capture_sequencer #(
    .DEPTH(16), .AW(4), .PRETRIG(4), .AUTO_TIMEOUT(50), .HOLDOFF(4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .adc_in      (adc_in),
    .trig_in     (trig_in),
    .arm         (arm),
    .abort       (abort),
    .single      (single),
    .auto_mode   (auto_mode),
    .force_trig  (force_trig),
    .rd          (rd_if),
    .busy        (busy),
    .state_o     (state_o),
    .missed_trig (missed_trig)
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  bit          rand_adc = 1'b0;
  logic [13:0] hist[$];

  typedef struct {
    int start;
    int delay;
    bit frc;
    bit am;
    int rmode;
    int exp_first;
  } vec_t;

  vec_t tbl[6];

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // one clock edge; hist[n] is the adc value sampled by edge n
  task automatic step();
    hist.push_back(adc_in);
    @(posedge clk);
    #1;
    adc_in = rand_adc ? 14'($urandom) : adc_in + 14'd1;
  endtask

  // arm, trigger after `delay` WAIT_TRIG edges (or let the timeout fire), then drain the window
  task automatic run_capture(input int delay, input bit frc, input bit am, input int rmode,
                             input bit use_model, input int exp_first, input bit pre_trig,
                             input bit ro_trig, input string tag);
    int          arm_edge, trig_edge, t, t_ro, t_v, expv;
    bit          done, prev_stall, prev_last;
    logic [13:0] prev_data;
    logic [13:0] got[$];
    bit          lst[$];
    auto_mode = am;
    arm_edge  = hist.size();
    arm = 1'b1;
    step();
    arm = 1'b0;
    for (int k = 0; k < 4; k++) begin
      trig_in = pre_trig && (k == 0);
      step();
    end
    trig_in = 1'b0;
    if (am) begin
      trig_edge = arm_edge + 5 + 49;
    end else begin
      for (int k = 0; k < delay; k++) step();
      trig_edge = hist.size();
      if (frc) force_trig = 1'b1;
      else trig_in = 1'b1;
      step();
      force_trig = 1'b0;
      trig_in    = 1'b0;
    end
    t = 0; t_ro = -1; t_v = -1; done = 0; prev_stall = 0; prev_last = 0; prev_data = '0;
    while (!done && t < 400) begin
      trig_in = 1'b0;
      case (rmode)
        0:       rd_if.rd_ready = 1'b1;
        1:       rd_if.rd_ready = (t % 2 == 0);
        default: rd_if.rd_ready = 1'($urandom_range(0, 1));
      endcase
      @(negedge clk);
      if (state_o == 3'd4 && t_ro < 0) begin
        t_ro = t;
        if (ro_trig) trig_in = 1'b1;
      end
      if (rd_if.rd_valid && t_v < 0) t_v = t;
      if (prev_stall) begin
        check({tag, " stall valid"}, rd_if.rd_valid, 1);
        check({tag, " stall data"}, rd_if.rd_data, prev_data);
        check({tag, " stall last"}, rd_if.rd_last, prev_last);
      end
      prev_stall = rd_if.rd_valid && !rd_if.rd_ready;
      prev_data  = rd_if.rd_data;
      prev_last  = rd_if.rd_last;
      if (rd_if.rd_valid && rd_if.rd_ready) begin
        got.push_back(rd_if.rd_data);
        lst.push_back(rd_if.rd_last);
        if (rd_if.rd_last) done = 1;
      end
      step();
      t++;
    end
    trig_in = 1'b0;
    rd_if.rd_ready = 1'b1;
    auto_mode = 1'b0;
    check({tag, " done"}, done, 1);
    check({tag, " nwords"}, got.size(), 16);
    check({tag, " latency"}, t_v - t_ro, 2);
    for (int i = 0; i < got.size() && i < 16; i++) begin
      expv = use_model ? int'(hist[trig_edge - 4 + i]) : ((exp_first + i) & 16'h3FFF);
      check($sformatf("%s word%0d", tag, i), got[i], expv);
      check($sformatf("%s last%0d", tag, i), lst[i], (i == 15) ? 1 : 0);
    end
    @(negedge clk);
    check({tag, " end state"}, state_o, single ? 0 : 5);
  endtask

  initial begin
    int   n;
    bit   seen;
    tbl[0] = '{start: 90,  delay: 5,  frc: 0, am: 0, rmode: 0, exp_first: 96};
    tbl[1] = '{start: 90,  delay: 5,  frc: 0, am: 0, rmode: 1, exp_first: 96};
    tbl[2] = '{start: 200, delay: 0,  frc: 0, am: 1, rmode: 0, exp_first: 250};
    tbl[3] = '{start: 300, delay: 3,  frc: 1, am: 0, rmode: 0, exp_first: 304};
    tbl[4] = '{start: 400, delay: 0,  frc: 0, am: 0, rmode: 2, exp_first: 401};
    tbl[5] = '{start: 500, delay: 11, frc: 0, am: 0, rmode: 1, exp_first: 512};
    rd_if.rd_ready = 1'b1;

    for (int i = 0; i < 3; i++) step();
    reset = 1'b0;
    @(negedge clk);
    check("reset state_o", state_o, 0);
    check("reset busy", busy, 0);
    check("reset rd_valid", rd_if.rd_valid, 0);
    check("reset rd_last", rd_if.rd_last, 0);
    check("reset rd_data", rd_if.rd_data, 0);
    check("reset missed", missed_trig, 0);

    for (int i = 0; i < 6; i++) begin
      adc_in = 14'(tbl[i].start);
      run_capture(tbl[i].delay, tbl[i].frc, tbl[i].am, tbl[i].rmode, 1'b0, tbl[i].exp_first,
                  1'b0, 1'b0, $sformatf("tbl%0d", i));
    end

    rand_adc = 1'b1;
    for (int i = 0; i < 6; i++) begin
      run_capture($urandom_range(0, 20), 1'($urandom_range(0, 1)), 1'b0, 2, 1'b1, 0,
                  1'b0, 1'b0, $sformatf("rnd%0d", i));
    end

    // abort in the middle of POST
    arm = 1'b1; step(); arm = 1'b0;
    for (int k = 0; k < 4; k++) step();
    trig_in = 1'b1; step(); trig_in = 1'b0;
    for (int k = 0; k < 3; k++) step();
    abort = 1'b1; step(); abort = 1'b0;
    @(negedge clk);
    check("abort state_o", state_o, 0);
    check("abort busy", busy, 0);
    seen = 0;
    for (int k = 0; k < 25; k++) begin
      step();
      @(negedge clk);
      if (rd_if.rd_valid) seen = 1;
    end
    check("abort no rd_valid", seen, 0);
    run_capture(2, 1'b0, 1'b0, 0, 1'b1, 0, 1'b0, 1'b0, "rearm");

    // continuous mode with triggers lost in PREFILL and READOUT
    single = 1'b0;
    run_capture(1, 1'b0, 1'b0, 0, 1'b1, 0, 1'b1, 1'b1, "cont");
    n = 1;
    for (int k = 0; k < 20; k++) begin
      step();
      @(negedge clk);
      if (state_o == 3'd5) n++;
      else break;
    end
    check("holdoff cycles", n, 4);
    check("after holdoff state", state_o, 1);
    check("missed_trig", missed_trig, 2);
    single = 1'b1;
    abort = 1'b1; step(); abort = 1'b0;

    // reset while a word is held on the stream
    arm = 1'b1; step(); arm = 1'b0;
    for (int k = 0; k < 4; k++) step();
    trig_in = 1'b1; step(); trig_in = 1'b0;
    rd_if.rd_ready = 1'b0;
    seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (rd_if.rd_valid) seen = 1;
      else step();
    end
    check("readout reached", seen, 1);
    reset = 1'b1; step(); reset = 1'b0;
    @(negedge clk);
    check("rst ro state_o", state_o, 0);
    check("rst ro busy", busy, 0);
    check("rst ro rd_valid", rd_if.rd_valid, 0);
    check("rst ro rd_last", rd_if.rd_last, 0);
    check("rst ro rd_data", rd_if.rd_data, 0);
    check("rst ro missed", missed_trig, 0);
    rd_if.rd_ready = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
